// File: rtl/alu_modexp_seq_if.sv
// Bus bundle for alu_modexp_seq: request/response signals plus the shared ALU port.
// The slave side is the sequencer; the master side is the requester that also hosts the ALU.
interface alu_modexp_seq_if #(
  parameter int N = 32
);
  logic         start_i;
  logic [N-1:0] base_i;
  logic [N-1:0] exp_i;
  logic [N-1:0] mod_i;
  logic         busy_o;
  logic         done_o;
  logic [N-1:0] result_o;
  logic         error_o;
  logic [2:0]   alu_opcode_o;
  logic [N-1:0] alu_a_o;
  logic [N-1:0] alu_b_o;
  logic [N-1:0] alu_result_i;

  modport slave (
    input  start_i, base_i, exp_i, mod_i, alu_result_i,
    output busy_o, done_o, result_o, error_o, alu_opcode_o, alu_a_o, alu_b_o
  );

  modport master (
    output start_i, base_i, exp_i, mod_i, alu_result_i,
    input  busy_o, done_o, result_o, error_o, alu_opcode_o, alu_a_o, alu_b_o
  );
endinterface

// File: rtl/alu_modexp_seq.sv
// Constant-time modular exponentiation sequencer driving a shared ALU with one ADD/MOD per cycle.
// Square-and-multiply over every exponent bit; each modmul is shift-and-add with a reduction after every ADD.
module alu_modexp_seq #(
  parameter int N = 32
) (
  input logic              clk,
  input logic              rst,
  alu_modexp_seq_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam logic [2:0]    OP_ADD = 3'b000;
  localparam logic [2:0]    OP_MOD = 3'b101;
  localparam logic [IW-1:0] LAST   = IW'(N - 1);
  localparam logic [N-1:0]  ONE    = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE, RED_B, RED_R, MM_DBL, MM_RD1, MM_ADD, MM_RD2, COMMIT, DONE
  } state_t;

  state_t        state, state_next;
  logic [2:0]    opcode_q, opcode_next;
  logic [N-1:0]  alu_a_q, alu_a_next;
  logic [N-1:0]  alu_b_q, alu_b_next;
  logic          busy_q, busy_next;
  logic          done_q, done_next;
  logic          error_q, error_next;
  logic [N-1:0]  result_q, result_next;
  logic [N-1:0]  exp_q, exp_next;
  logic [N-1:0]  n_q, n_next;
  logic [N-1:0]  b_val, b_val_next;
  logic [N-1:0]  r_val, r_val_next;
  logic [N-1:0]  acc_q, acc_next;
  logic [IW-1:0] i_q, i_next;
  logic [IW-1:0] j_q, j_next;
  logic          phase_q, phase_next;
  logic [N-1:0]  mul_x;

  // phase 0 multiplies r*b, phase 1 squares b; the multiplier operand is b in both
  assign mul_x = phase_q ? b_val : r_val;

  always_comb begin
    state_next  = state;
    opcode_next = OP_ADD;
    alu_a_next  = '0;
    alu_b_next  = '0;
    busy_next   = busy_q;
    done_next   = 1'b0;
    error_next  = error_q;
    result_next = result_q;
    exp_next    = exp_q;
    n_next      = n_q;
    b_val_next  = b_val;
    r_val_next  = r_val;
    acc_next    = acc_q;
    i_next      = i_q;
    j_next      = j_q;
    phase_next  = phase_q;

    case (state)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.mod_i == '0 || bus.mod_i[N-1]) begin
            state_next  = DONE;
            done_next   = 1'b1;
            error_next  = 1'b1;
            result_next = '0;
          end else begin
            state_next  = RED_B;
            busy_next   = 1'b1;
            error_next  = 1'b0;
            exp_next    = bus.exp_i;
            n_next      = bus.mod_i;
            opcode_next = OP_MOD;
            alu_a_next  = bus.base_i;
            alu_b_next  = bus.mod_i;
          end
        end
      end
      RED_B: begin
        b_val_next  = bus.alu_result_i;
        state_next  = RED_R;
        opcode_next = OP_MOD;
        alu_a_next  = ONE;
        alu_b_next  = n_q;
      end
      RED_R: begin
        r_val_next = bus.alu_result_i;
        acc_next   = '0;
        i_next     = '0;
        j_next     = LAST;
        phase_next = 1'b0;
        state_next = MM_DBL;
      end
      MM_DBL: begin
        state_next  = MM_RD1;
        opcode_next = OP_MOD;
        alu_a_next  = bus.alu_result_i;
        alu_b_next  = n_q;
      end
      MM_RD1: begin
        acc_next    = bus.alu_result_i;
        state_next  = MM_ADD;
        alu_a_next  = bus.alu_result_i;
        alu_b_next  = b_val[j_q] ? mul_x : '0;
      end
      MM_ADD: begin
        state_next  = MM_RD2;
        opcode_next = OP_MOD;
        alu_a_next  = bus.alu_result_i;
        alu_b_next  = n_q;
      end
      MM_RD2: begin
        acc_next = bus.alu_result_i;
        if (j_q == '0) begin
          state_next = COMMIT;
        end else begin
          j_next     = j_q - 1'b1;
          state_next = MM_DBL;
          alu_a_next = bus.alu_result_i;
          alu_b_next = bus.alu_result_i;
        end
      end
      COMMIT: begin
        // the next modmul starts from acc=0, so ADD 0,0 is already its first doubling
        acc_next   = '0;
        j_next     = LAST;
        state_next = MM_DBL;
        if (!phase_q) begin
          if (exp_q[i_q]) r_val_next = acc_q;
          phase_next = 1'b1;
        end else begin
          b_val_next = acc_q;
          phase_next = 1'b0;
          if (i_q == LAST) begin
            state_next  = DONE;
            busy_next   = 1'b0;
            done_next   = 1'b1;
            error_next  = 1'b0;
            result_next = r_val;
          end else begin
            i_next = i_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        error_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opcode_q <= OP_ADD;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      b_val    <= '0;
      r_val    <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      phase_q  <= 1'b0;
    end else begin
      state    <= state_next;
      opcode_q <= opcode_next;
      alu_a_q  <= alu_a_next;
      alu_b_q  <= alu_b_next;
      busy_q   <= busy_next;
      done_q   <= done_next;
      error_q  <= error_next;
      result_q <= result_next;
      exp_q    <= exp_next;
      n_q      <= n_next;
      b_val    <= b_val_next;
      r_val    <= r_val_next;
      acc_q    <= acc_next;
      i_q      <= i_next;
      j_q      <= j_next;
      phase_q  <= phase_next;
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.error_o      = error_q;
  assign bus.result_o     = result_q;
  assign bus.alu_opcode_o = opcode_q;
  assign bus.alu_a_o      = alu_a_q;
  assign bus.alu_b_o      = alu_b_q;
endmodule

// File: doc/alu_modexp_seq.md
# alu_modexp_seq

Sequencer that drives the shared ALU's operand/opcode port to compute modular exponentiation, result = base^exp mod n, for the RSA pipeline. It issues exactly one ALU operation per cycle: ADD 000 to double and accumulate, and MOD 101 to reduce. It captures the ALU result on the following edge. Runtime is fixed for a given N, regardless of operand values, so timing does not leak the exponent.

## Interface
- N, 32, operand/result width; must match the ALU's N
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request; sampled only in IDLE
- base_i  in  N  base; any value, reduced internally
- exp_i  in  N  exponent
- mod_i  in  N  modulus; legal range 2..2^(N-1)-1, and 1 is accepted (see Operation)
- busy_o  out  1  high from the cycle after start is accepted until done
- done_o  out  1  one-cycle completion pulse
- result_o  out  N  result, valid while done_o=1 and held until the next accepted start
- error_o  out  1  qualifies done_o; illegal modulus
- alu_opcode_o  out  3  ALU opcode (000 ADD, 101 MOD only)
- alu_a_o  out  N  ALU operand a
- alu_b_o  out  N  ALU operand b
- alu_result_i  in  N  ALU result (combinational in the ALU)

## Operation
- All outputs are registered. The ALU result for the operands driven in cycle k is captured at the end of cycle k.
- Reset values: busy_o=0, done_o=0, result_o=0, error_o=0, alu_opcode_o=000, alu_a_o=0, alu_b_o=0. The block is in IDLE.
- In IDLE, the ALU port is driven with ADD 0,0.
- On a start in IDLE, base_i, exp_i and mod_i are latched. Later input changes are ignored.
- A start while busy is ignored.
- Error check at start: mod_i==0 or mod_i[N-1]==1.
  - The error case issues no ALU operations and does not raise busy.
  - Next cycle: done_o=1, error_o=1, result_o=0.
- States: IDLE, RED_B, RED_R, MM_DBL, MM_RD1, MM_ADD, MM_RD2, COMMIT, DONE.
- RED_B drives MOD base,n; the result goes to b.
- RED_R drives MOD 1,n; the result goes to r. This is why n=1 gives result 0.
- Exponent loop, i = 0..N-1 from the LSB; all N bits always execute:
  - modmul(r,b) into t; r=t only if exp[i]=1.
  - Then modmul(b,b) into b.
- modmul(x,y): acc=0, then for j = N-1 down to 0, four cycles per j:
  - MM_DBL: ADD acc,acc.
  - MM_RD1: MOD result,n.
  - MM_ADD: ADD acc, (y[j] ? x : 0).
  - MM_RD2: MOD result,n.
  - After the last j, one COMMIT cycle writes the destination. Total 4N+1 cycles.
- Width rule: acc<n and x<n with n<2^(N-1), so every ADD result is below 2^N and never wraps.
- DONE: result_o=r, done_o=1 for one cycle, busy_o=0, then return to IDLE.
- Reset mid-operation has priority: the next cycle shows reset values and IDLE, and partial state is discarded.
- rst and start_i in the same cycle: reset wins and the start is dropped.

## Timing
- Edge 0 is the edge that samples start_i=1.
- busy_o is high from edge 0 onward.
- Edges 1 and 2 capture the b and r reductions.
- Each modmul occupies 4N+1 edges, and there are 2N modmuls.
- done_o is high in the single cycle after edge 2N(4N+1)+2 (N=8: edge 530; N=32: edge 8258).
- busy_o falls in the same cycle done_o rises.
- Error path: done_o and error_o are high in the cycle after edge 0.
- A new start is accepted in the cycle after done_o, giving back-to-back operation with one IDLE cycle.
- ALU port sequence per modmul bit, checkable in the bench:
  - opcode 000, 101, 000, 101.
  - alu_b_o=n on every MOD.

## Test plan
- N=8, base=4, exp=13, mod=127 -> done_o after edge 530, result_o=32, error_o=0; busy_o high during edges 0..530.
- N=8, base=200, exp=0, mod=127 -> result_o=1 (base reduced to 73 but never committed); base=7, exp=2, mod=13 -> result_o=10.
- N=8, mod=1, base=5, exp=3 -> result_o=0, error_o=0, full 530-edge latency.
- N=8, mod=0, then mod=128 -> each gives done_o=1 and error_o=1 in the cycle after the start edge, result_o=0, ALU port stays ADD 0,0.
- N=8, start (base=4, exp=13, mod=127), a second start at edge 50 with other operands, rst at edge 100 -> the edge-50 start is ignored; after reset all outputs are 0 and no done_o appears. A new start (base=2, exp=10, mod=125) -> result_o=24.
- N=8, random base/exp and odd mod < 128 over 200 runs against a software model -> result_o matches. ALU opcodes are only 000/101, with no ADD result ≥ 2^8.
